// File: rtl/branch_stack.sv
// branch_stack: branch checkpoint store with the live branch mask, resolving branches
// into clear broadcasts or same-cycle map/free-list/ROB restores.
package branch_stack_pkg;
   localparam int B_MASK_WIDTH = 4;
   localparam int ARCH_REG_SZ = 32;
   localparam int PHYS_REG_SZ = 64;
   localparam int PHYS_REG_IDX = $clog2(PHYS_REG_SZ);
   localparam int ROB_SZ = 32;
   localparam int ROB_IDX = $clog2(ROB_SZ);
   typedef struct packed {
      logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] map_table;
      logic [PHYS_REG_SZ-1:0] free_list;
      logic [ROB_IDX-1:0] rob_tail;
      logic [B_MASK_WIDTH-1:0] b_m;
   } BS_ENTRY_PACKET;
endpackage

module branch_stack
   import branch_stack_pkg::*;
(
   input logic clock,
   input logic reset,
   input BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] bs_entries_in,
   input logic [B_MASK_WIDTH-1:0] next_b_mask,
   input logic resolve_valid,
   input logic [B_MASK_WIDTH-1:0] resolve_mask,
   input logic resolve_mispredict,
   input logic [31:0] resolve_target_PC,
   input logic [PHYS_REG_SZ-1:0] retire_free_regs,
   output logic [B_MASK_WIDTH-1:0] b_mask_combinational,
   output logic [B_MASK_WIDTH-1:0] clear_mask,
   output logic [B_MASK_WIDTH-1:0] squash_mask,
   output logic restore_valid,
   output logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] map_table_restore,
   output logic [PHYS_REG_SZ-1:0] free_list_restore,
   output logic [ROB_IDX-1:0] rob_tail_restore,
   output logic [31:0] restore_PC
);
   logic [B_MASK_WIDTH-1:0] b_mask;
   BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] entries;
   BS_ENTRY_PACKET sel;
   logic [B_MASK_WIDTH-1:0] dependents;
   logic hit, correct, mispredict;

   // Non-one-hot or stale resolutions are dropped entirely.
   assign hit = !reset && resolve_valid && $onehot(resolve_mask) && |(resolve_mask & b_mask);
   assign correct = hit && !resolve_mispredict;
   assign mispredict = hit && resolve_mispredict;

   always_comb begin
      sel = '0;
      dependents = '0;
      for (int k = 0; k < B_MASK_WIDTH; k++) begin
         sel = resolve_mask[k] ? entries[k] : sel;
         dependents[k] = b_mask[k] && |(entries[k].b_m & resolve_mask);
      end
   end

   assign restore_valid = mispredict;
   assign clear_mask = correct ? resolve_mask : '0;
   assign squash_mask = mispredict ? (resolve_mask | dependents) : '0;
   assign b_mask_combinational = reset ? '0 : (b_mask & ~clear_mask & ~squash_mask);
   assign map_table_restore = mispredict ? sel.map_table : '0;
   assign free_list_restore = mispredict ? (sel.free_list | retire_free_regs) : '0;
   assign rob_tail_restore = mispredict ? sel.rob_tail : '0;
   assign restore_PC = mispredict ? resolve_target_PC : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         b_mask <= '0;
         entries <= '0;
      end else begin
         b_mask <= restore_valid ? b_mask_combinational : next_b_mask;
         for (int k = 0; k < B_MASK_WIDTH; k++) begin
            if (!restore_valid && next_b_mask[k] && !b_mask_combinational[k]) begin
               entries[k] <= bs_entries_in[k];
               entries[k].free_list <= bs_entries_in[k].free_list | retire_free_regs;
               entries[k].b_m <= bs_entries_in[k].b_m & ~clear_mask;
            end else begin
               // Keep snapshots current with regs retired after the checkpoint.
               entries[k].free_list <= b_mask[k] ? (entries[k].free_list | retire_free_regs) : entries[k].free_list;
               entries[k].b_m <= entries[k].b_m & ~clear_mask;
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_stack.sv
// tb_branch_stack: directed vectors with hand-computed expectations for branch_stack.
module tb_branch_stack;
   import branch_stack_pkg::*;
   logic clock = 0;
   logic reset;
   BS_ENTRY_PACKET [B_MASK_WIDTH-1:0] ent;
   logic [B_MASK_WIDTH-1:0] next_b_mask;
   logic resolve_valid;
   logic [B_MASK_WIDTH-1:0] resolve_mask;
   logic resolve_mispredict;
   logic [31:0] resolve_target_PC;
   logic [PHYS_REG_SZ-1:0] retire_free_regs;
   logic [B_MASK_WIDTH-1:0] b_mask_combinational, clear_mask, squash_mask;
   logic restore_valid;
   logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] map_table_restore;
   logic [PHYS_REG_SZ-1:0] free_list_restore;
   logic [ROB_IDX-1:0] rob_tail_restore;
   logic [31:0] restore_PC;
   int checks = 0;
   int errors = 0;

   branch_stack dut (
      .clock(clock), .reset(reset), .bs_entries_in(ent), .next_b_mask(next_b_mask),
      .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
      .resolve_mispredict(resolve_mispredict), .resolve_target_PC(resolve_target_PC),
      .retire_free_regs(retire_free_regs), .b_mask_combinational(b_mask_combinational),
      .clear_mask(clear_mask), .squash_mask(squash_mask), .restore_valid(restore_valid),
      .map_table_restore(map_table_restore), .free_list_restore(free_list_restore),
      .rob_tail_restore(rob_tail_restore), .restore_PC(restore_PC)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      resolve_valid = 0;
      resolve_mask = '0;
      resolve_mispredict = 0;
      resolve_target_PC = '0;
      retire_free_regs = '0;
      ent = '0;
   endtask

   task automatic resolve(input logic [3:0] m, input logic mis, input logic [31:0] pc);
      resolve_valid = 1;
      resolve_mask = m;
      resolve_mispredict = mis;
      resolve_target_PC = pc;
   endtask

   task automatic quiet(input string tag);
      check({tag, "_restore"}, 64'(restore_valid), 64'd0);
      check({tag, "_clear"}, 64'(clear_mask), 64'd0);
      check({tag, "_squash"}, 64'(squash_mask), 64'd0);
      check({tag, "_pc"}, 64'(restore_PC), 64'd0);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
      idle();
   endtask

   initial begin
      reset = 1;
      next_b_mask = '0;
      idle();
      #2;
      check("reset_bmc", 64'(b_mask_combinational), 64'd0);
      quiet("reset");
      next_cycle();
      next_cycle();
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("idle_bmc", 64'(b_mask_combinational), 64'd0);
         quiet("idle");
         next_cycle();
      end
      // allocate slot 0 then resolve it correctly
      ent[0].map_table[5] = 6'd40;
      ent[0].rob_tail = 5'd7;
      next_b_mask = 4'b0001;
      next_cycle();
      resolve(4'b0001, 0, 32'h0);
      next_b_mask = 4'b0000;
      #2;
      check("corr_clear", 64'(clear_mask), 64'b0001);
      check("corr_bmc", 64'(b_mask_combinational), 64'b0000);
      check("corr_restore", 64'(restore_valid), 64'd0);
      next_cycle();
      #2;
      check("corr_after_bmc", 64'(b_mask_combinational), 64'b0000);
      next_cycle();
      // nested checkpoints, mispredict the middle one
      ent[0].map_table[5] = 6'd41;
      ent[0].rob_tail = 5'd3;
      next_b_mask = 4'b0001;
      next_cycle();
      ent[1].map_table[5] = 6'd42;
      ent[1].rob_tail = 5'd9;
      ent[1].b_m = 4'b0001;
      next_b_mask = 4'b0011;
      next_cycle();
      ent[2].map_table[5] = 6'd43;
      ent[2].rob_tail = 5'd12;
      ent[2].b_m = 4'b0011;
      next_b_mask = 4'b0111;
      next_cycle();
      resolve(4'b0010, 1, 32'h120);
      #2;
      check("mis1_restore", 64'(restore_valid), 64'd1);
      check("mis1_squash", 64'(squash_mask), 64'b0110);
      check("mis1_bmc", 64'(b_mask_combinational), 64'b0001);
      check("mis1_pc", 64'(restore_PC), 64'h120);
      check("mis1_map5", 64'(map_table_restore[5]), 64'd42);
      check("mis1_tail", 64'(rob_tail_restore), 64'd9);
      check("mis1_clear", 64'(clear_mask), 64'd0);
      next_cycle();
      next_b_mask = 4'b0001;
      #2;
      check("mis1_after_bmc", 64'(b_mask_combinational), 64'b0001);
      next_cycle();
      resolve(4'b0001, 1, 32'h200);
      next_b_mask = 4'b0000;
      #2;
      check("surv_squash", 64'(squash_mask), 64'b0001);
      check("surv_map5", 64'(map_table_restore[5]), 64'd41);
      check("surv_tail", 64'(rob_tail_restore), 64'd3);
      check("surv_bmc", 64'(b_mask_combinational), 64'b0000);
      next_cycle();
      // fill all four, free slot 2 and reallocate it in the same cycle
      for (int k = 0; k < 4; k++) begin
         ent[k].b_m = 4'((1 << k) - 1);
         ent[k].map_table[1] = 6'(50 + k);
         ent[k].rob_tail = 5'(k);
         next_b_mask = 4'((1 << (k + 1)) - 1);
         next_cycle();
      end
      next_b_mask = 4'b1111;
      #2;
      check("full_bmc", 64'(b_mask_combinational), 64'b1111);
      quiet("full");
      next_cycle();
      resolve(4'b0100, 0, 32'h0);
      ent[2].b_m = 4'b1011;
      ent[2].map_table[1] = 6'd60;
      ent[2].rob_tail = 5'd20;
      #2;
      check("realloc_clear", 64'(clear_mask), 64'b0100);
      check("realloc_bmc", 64'(b_mask_combinational), 64'b1011);
      next_cycle();
      #2;
      check("realloc_after_bmc", 64'(b_mask_combinational), 64'b1111);
      next_cycle();
      resolve(4'b0100, 1, 32'h300);
      next_b_mask = 4'b1011;
      #2;
      check("realloc_squash", 64'(squash_mask), 64'b0100);
      check("realloc_map1", 64'(map_table_restore[1]), 64'd60);
      check("realloc_tail", 64'(rob_tail_restore), 64'd20);
      check("realloc_mis_bmc", 64'(b_mask_combinational), 64'b1011);
      next_cycle();
      resolve(4'b0001, 1, 32'h310);
      next_b_mask = 4'b0000;
      #2;
      check("slot0_squash", 64'(squash_mask), 64'b1011);
      check("slot0_bmc", 64'(b_mask_combinational), 64'b0000);
      check("slot0_map1", 64'(map_table_restore[1]), 64'd50);
      next_cycle();
      // free-list upkeep and concurrent retire; dispatch write dropped by restore
      ent[0].free_list = 64'h1;
      ent[0].rob_tail = 5'd5;
      next_b_mask = 4'b0001;
      next_cycle();
      next_cycle();
      retire_free_regs = 64'h200;
      next_cycle();
      resolve(4'b0001, 1, 32'h400);
      retire_free_regs = 64'h1000;
      ent[1].rob_tail = 5'd30;
      next_b_mask = 4'b0011;
      #2;
      check("fl_restore", free_list_restore, 64'h1201);
      check("fl_tail", 64'(rob_tail_restore), 64'd5);
      check("fl_bmc", 64'(b_mask_combinational), 64'b0000);
      next_cycle();
      next_b_mask = 4'b0000;
      #2;
      check("drop_bmc", 64'(b_mask_combinational), 64'b0000);
      next_cycle();
      // stale and non-one-hot resolutions are ignored
      ent[0].map_table[2] = 6'd33;
      ent[0].rob_tail = 5'd11;
      next_b_mask = 4'b0001;
      next_cycle();
      resolve(4'b1000, 1, 32'h500);
      #2;
      check("stale_bmc", 64'(b_mask_combinational), 64'b0001);
      quiet("stale");
      check("stale_map2", 64'(map_table_restore[2]), 64'd0);
      check("stale_tail", 64'(rob_tail_restore), 64'd0);
      check("stale_fl", free_list_restore, 64'd0);
      next_cycle();
      resolve(4'b0011, 1, 32'h510);
      #2;
      quiet("multi");
      check("multi_bmc", 64'(b_mask_combinational), 64'b0001);
      next_cycle();
      resolve(4'b0001, 1, 32'h520);
      #2;
      check("kept_map2", 64'(map_table_restore[2]), 64'd33);
      check("kept_tail", 64'(rob_tail_restore), 64'd11);
      // reset overrides a restore
      reset = 1;
      #1;
      check("rst_mid_restore", 64'(restore_valid), 64'd0);
      check("rst_mid_bmc", 64'(b_mask_combinational), 64'd0);
      next_cycle();
      reset = 0;
      next_b_mask = 4'b0000;
      resolve(4'b0001, 1, 32'h530);
      #2;
      quiet("post_rst");
      check("post_rst_bmc", 64'(b_mask_combinational), 64'd0);
      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
